// File: rtl/stream_unpacker_pkg.sv
// Shared video definitions for the pixel packer / unpacker pair.
// Holds default frame geometry, group sizing (4 pixels in 3 words),
// the packing phase enum and the RGB pixel type.
package stream_unpacker_pkg;

   localparam int X_SIZE_DEF      = 640;
   localparam int Y_SIZE_DEF      = 480;
   localparam int PIX_PER_GROUP   = 4;
   localparam int WORDS_PER_GROUP = 3;

   // PH0..PH2 consume word 0..2 of a group, PH3 emits the held fourth pixel.
   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } phase_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   // Split a packed 24-bit {r,g,b} value into its colour fields.
   function automatic pixel_t unpack_px(input logic [23:0] p);
      pixel_t px;
      px.r = p[23:16];
      px.g = p[15:8];
      px.b = p[7:0];
      return px;
   endfunction

endpackage

// File: rtl/unpack_framing_check.sv
// Input framing checker for the stream unpacker.
// Tracks the word-within-line and line-within-frame counters of the input
// stream and raises one-cycle error pulses for tuser/tlast/tkeep violations.
// Ports:
//   aclk, aresetn   clock, async active-low reset
//   accept_i        input word handshake (tvalid & tready)
//   tuser_i/tlast_i/tkeep_i  sideband of the accepted word
//   at_ph0_i        unpacker phase is PH0
//   resync_o        combinational: this word restarts the frame (tuser seen early)
//   sof_err_o, eol_err_o, keep_err_o  registered one-cycle error pulses
module unpack_framing_check
   import stream_unpacker_pkg::*;
#(
   parameter int X_SIZE = X_SIZE_DEF,
   parameter int Y_SIZE = Y_SIZE_DEF
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       accept_i,
   input  logic       tuser_i,
   input  logic       tlast_i,
   input  logic [3:0] tkeep_i,
   input  logic       at_ph0_i,
   output logic       resync_o,
   output logic       sof_err_o,
   output logic       eol_err_o,
   output logic       keep_err_o
);

   localparam int WPL = WORDS_PER_GROUP * X_SIZE / PIX_PER_GROUP;
   localparam int WW  = $clog2(WPL + 1);
   localparam int LW  = $clog2(Y_SIZE + 1);
   localparam logic [WW-1:0] WCNT_LAST = WW'(WPL - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(Y_SIZE - 1);

   logic [WW-1:0] wcnt_q, wcnt_d, wcnt_eff_s;
   logic [LW-1:0] line_q, line_d, line_eff_s;
   logic          sof_err_q, sof_err_d;
   logic          eol_err_q, eol_err_d;
   logic          keep_err_q, keep_err_d;
   logic          start_exp_s;
   logic          resync_s;

   // Error detection and counter advance; counters follow the expected
   // word count, tlast only produces an error.
   always_comb begin
      wcnt_d      = wcnt_q;
      line_d      = line_q;
      sof_err_d   = 1'b0;
      eol_err_d   = 1'b0;
      keep_err_d  = 1'b0;
      resync_s    = 1'b0;
      wcnt_eff_s  = wcnt_q;
      line_eff_s  = line_q;
      start_exp_s = at_ph0_i && (wcnt_q == '0) && (line_q == '0);
      if (accept_i) begin
         resync_s   = tuser_i && !start_exp_s;
         sof_err_d  = (tuser_i != start_exp_s);
         keep_err_d = (tkeep_i != 4'hF);
         if (resync_s) begin
            // Early tuser: this word becomes word 0 of line 0.
            wcnt_eff_s = '0;
            line_eff_s = '0;
         end else begin
            wcnt_eff_s = wcnt_q;
            line_eff_s = line_q;
         end
         eol_err_d = (tlast_i != (wcnt_eff_s == WCNT_LAST));
         if (wcnt_eff_s == WCNT_LAST) begin
            wcnt_d = '0;
            if (line_eff_s == LINE_LAST) begin
               line_d = '0;
            end else begin
               line_d = line_eff_s + LW'(1);
            end
         end else begin
            wcnt_d = wcnt_eff_s + WW'(1);
            line_d = line_eff_s;
         end
      end else begin
         resync_s = 1'b0;
      end
   end

   // Counter and error-pulse registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wcnt_q     <= '0;
         line_q     <= '0;
         sof_err_q  <= 1'b0;
         eol_err_q  <= 1'b0;
         keep_err_q <= 1'b0;
      end else begin
         wcnt_q     <= wcnt_d;
         line_q     <= line_d;
         sof_err_q  <= sof_err_d;
         eol_err_q  <= eol_err_d;
         keep_err_q <= keep_err_d;
      end
   end

   assign resync_o   = resync_s;
   assign sof_err_o  = sof_err_q;
   assign eol_err_o  = eol_err_q;
   assign keep_err_o = keep_err_q;

endmodule

// File: rtl/stream_unpacker.sv
// AXI4-Stream video sink: unpacks 3 x 32-bit words into 4 x 24-bit RGB
// pixels and emits one pixel per handshake, tagged with its x/y position.
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   in_stream_*            AXI4-Stream input (tuser = SOF, tlast = EOL)
//   pix_r/g/b, pix_x/y     pixel colour and position
//   pix_sof, pix_eol       first pixel of frame / last pixel of line
//   pix_valid, pix_ready   output handshake
//   sof_err, eol_err, keep_err  one-cycle framing error pulses
//   frame_done             one-cycle pulse, registered the cycle after the
//                          last pixel of a frame is handed off
module stream_unpacker
   import stream_unpacker_pkg::*;
#(
   parameter int X_SIZE = X_SIZE_DEF,
   parameter int Y_SIZE = Y_SIZE_DEF
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] in_stream_tdata,
   input  logic [3:0]  in_stream_tkeep,
   input  logic        in_stream_tlast,
   input  logic        in_stream_tuser,
   input  logic        in_stream_tvalid,
   output logic        in_stream_tready,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        sof_err,
   output logic        eol_err,
   output logic        keep_err,
   output logic        frame_done
);

   localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
   localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

   phase_e      phase_q, phase_d, phase_eff_s;
   logic [23:0] res_q, res_d;
   pixel_t      pix_q, pix_d;
   logic [9:0]  pix_x_q, pix_x_d;
   logic [8:0]  pix_y_q, pix_y_d;
   logic        pix_sof_q, pix_sof_d;
   logic        pix_eol_q, pix_eol_d;
   logic        pix_valid_q, pix_valid_d;
   logic [9:0]  pos_x_q, pos_x_d, x_here_s;
   logic [8:0]  pos_y_q, pos_y_d, y_here_s;
   logic        frame_done_q, frame_done_d;
   logic        free_s, accept_s, resync_s, load_s;
   logic [23:0] load_px_s;

   assign free_s           = !pix_valid_q || pix_ready;
   assign in_stream_tready = (phase_q != PH3) && free_s;
   assign accept_s         = in_stream_tvalid && in_stream_tready;

   unpack_framing_check #(
      .X_SIZE (X_SIZE),
      .Y_SIZE (Y_SIZE)
   ) u_check (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .accept_i   (accept_i_s()),
      .tuser_i    (in_stream_tuser),
      .tlast_i    (in_stream_tlast),
      .tkeep_i    (in_stream_tkeep),
      .at_ph0_i   (phase_q == PH0),
      .resync_o   (resync_s),
      .sof_err_o  (sof_err),
      .eol_err_o  (eol_err),
      .keep_err_o (keep_err)
   );

   function automatic logic accept_i_s();
      return accept_s;
   endfunction

   // Phase FSM and residue: each accepted word yields one pixel and leaves
   // the unused high bytes as residue for the next phase.
   always_comb begin
      phase_d     = phase_q;
      res_d       = res_q;
      load_s      = 1'b0;
      load_px_s   = 24'h000000;
      phase_eff_s = resync_s ? PH0 : phase_q;
      if (accept_s) begin
         load_s = 1'b1;
         case (phase_eff_s)
            PH0: begin
               load_px_s = in_stream_tdata[23:0];
               res_d     = {16'h0000, in_stream_tdata[31:24]};
               phase_d   = PH1;
            end
            PH1: begin
               load_px_s = {in_stream_tdata[15:0], res_q[7:0]};
               res_d     = {8'h00, in_stream_tdata[31:16]};
               phase_d   = PH2;
            end
            PH2: begin
               load_px_s = {in_stream_tdata[7:0], res_q[15:0]};
               res_d     = in_stream_tdata[31:8];
               phase_d   = PH3;
            end
            default: begin
               // PH3 never accepts (tready is low); hold state.
               load_s  = 1'b0;
               phase_d = phase_q;
            end
         endcase
      end else if ((phase_q == PH3) && free_s) begin
         load_s    = 1'b1;
         load_px_s = res_q;
         res_d     = 24'h000000;
         phase_d   = PH0;
      end else begin
         load_s = 1'b0;
      end
   end

   // Output register and position counters; a resync pixel lands at (0,0).
   always_comb begin
      pix_d        = pix_q;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_sof_d    = pix_sof_q;
      pix_eol_d    = pix_eol_q;
      pix_valid_d  = pix_valid_q;
      pos_x_d      = pos_x_q;
      pos_y_d      = pos_y_q;
      x_here_s     = resync_s ? 10'd0 : pos_x_q;
      y_here_s     = resync_s ? 9'd0 : pos_y_q;
      frame_done_d = pix_valid_q && pix_ready && (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);
      if (load_s) begin
         pix_valid_d = 1'b1;
         pix_d       = unpack_px(load_px_s);
         pix_x_d     = x_here_s;
         pix_y_d     = y_here_s;
         pix_sof_d   = (x_here_s == 10'd0) && (y_here_s == 9'd0);
         pix_eol_d   = (x_here_s == X_LAST);
         if (x_here_s == X_LAST) begin
            pos_x_d = 10'd0;
            if (y_here_s == Y_LAST) begin
               pos_y_d = 9'd0;
            end else begin
               pos_y_d = y_here_s + 9'd1;
            end
         end else begin
            pos_x_d = x_here_s + 10'd1;
            pos_y_d = y_here_s;
         end
      end else if (pix_ready) begin
         pix_valid_d = 1'b0;
      end else begin
         pix_valid_d = pix_valid_q;
      end
   end

   // State, output and pulse registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         phase_q      <= PH0;
         res_q        <= 24'h000000;
         pix_q        <= '0;
         pix_x_q      <= 10'd0;
         pix_y_q      <= 9'd0;
         pix_sof_q    <= 1'b0;
         pix_eol_q    <= 1'b0;
         pix_valid_q  <= 1'b0;
         pos_x_q      <= 10'd0;
         pos_y_q      <= 9'd0;
         frame_done_q <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         res_q        <= res_d;
         pix_q        <= pix_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_sof_q    <= pix_sof_d;
         pix_eol_q    <= pix_eol_d;
         pix_valid_q  <= pix_valid_d;
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign pix_r      = pix_q.r;
   assign pix_g      = pix_q.g;
   assign pix_b      = pix_q.b;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign pix_sof    = pix_sof_q;
   assign pix_eol    = pix_eol_q;
   assign pix_valid  = pix_valid_q;
   assign frame_done = frame_done_q;

endmodule
